// File: rtl/rf_dump_scanner_if.sv
// rtl/rf_dump_scanner_if.sv - record stream carrying register index and value
interface rf_dump_scanner_if #(
    parameter int IDX_W = 5
);
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [31:0]      out_data;

    modport master (
        output out_valid,
        output out_idx,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/rf_dump_scanner.sv
// rtl/rf_dump_scanner.sv - register file dump streamer with optional changed-only mode
module rf_dump_scanner #(
    parameter int NREG  = 32,
    parameter int IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 diff_only,
    output logic [IDX_W-1:0]     reg_sel,
    input  logic [31:0]          reg_data,
    rf_dump_scanner_if.master    out,
    output logic                 busy,
    output logic                 done,
    output logic [5:0]           count
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREG - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_SEND,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [IDX_W-1:0] idx;
    logic             mode;
    logic             out_valid_r;
    logic [IDX_W-1:0] out_idx_r;
    logic [31:0]      out_data_r;
    logic [5:0]       count_r;
    logic [31:0]      shadow [NREG];

    logic             last;
    logic             skip;
    logic             handshake;
    logic             capture;
    logic             advance;
    logic             accept;

    assign reg_sel       = idx;
    assign out.out_valid = out_valid_r;
    assign out.out_idx   = out_idx_r;
    assign out.out_data  = out_data_r;
    assign count         = count_r;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Decides the step for the current register; the datapath below only follows these strobes.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        advance    = 1'b0;
        accept     = 1'b0;
        last       = (idx == LAST_IDX);
        skip       = mode && (reg_data == shadow[idx]);
        handshake  = out_valid_r && out.out_ready;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (skip) begin
                    advance    = !last;
                    state_next = last ? S_DONE : S_SCAN;
                end else begin
                    capture    = 1'b1;
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (handshake) begin
                    advance    = !last;
                    state_next = last ? S_DONE : S_SCAN;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            mode        <= 1'b0;
            out_valid_r <= 1'b0;
            out_idx_r   <= '0;
            out_data_r  <= '0;
            count_r     <= '0;
            for (int i = 0; i < NREG; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            if (accept) begin
                mode    <= diff_only;
                idx     <= '0;
                count_r <= '0;
            end
            if (advance) begin
                idx <= idx + IDX_W'(1);
            end
            if (state == S_DONE) begin
                idx <= '0;
            end
            // The record is frozen here so later register writes cannot disturb it while stalled.
            if (capture) begin
                out_data_r  <= reg_data;
                out_idx_r   <= idx;
                shadow[idx] <= reg_data;
                out_valid_r <= 1'b1;
                count_r     <= count_r + 6'd1;
            end
            if (state == S_SEND && handshake) begin
                out_valid_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rf_dump_scanner.sv
// tb/tb_rf_dump_scanner.sv - scoreboard bench for rf_dump_scanner
module tb_rf_dump_scanner;
    localparam int NREG  = 32;
    localparam int IDX_W = 5;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [31:0]      data;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             diff_only;
    logic [IDX_W-1:0] reg_sel;
    logic [31:0]      reg_data;
    logic             busy;
    logic             done;
    logic [5:0]       count;

    logic [31:0] rf [NREG];
    logic [31:0] sh [NREG];
    rec_t        q[$];

    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cnt = 0;
    int          exp_lat = 0;
    logic [5:0]  exp_cnt = '0;

    rf_dump_scanner_if #(.IDX_W(IDX_W)) ob ();

    rf_dump_scanner #(.NREG(NREG), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .diff_only (diff_only),
        .reg_sel   (reg_sel),
        .reg_data  (reg_data),
        .out       (ob.master),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    assign reg_data = (reg_sel == '0) ? 32'h0 : rf[reg_sel];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        rec_t r;
        if (!rst) begin
            if (start && !busy) start_cyc = cyc;
            if (ob.out_valid && ob.out_ready) begin
                if (q.size() == 0) begin
                    check("extra_record", {27'd0, ob.out_idx}, 32'hFFFF_FFFF);
                end else begin
                    r = q.pop_front();
                    check("rec_idx", {27'd0, ob.out_idx}, {27'd0, r.idx});
                    check("rec_data", ob.out_data, r.data);
                end
            end
            if (done) begin
                done_cnt++;
                check("done_cycle", 32'(cyc - start_cyc), 32'(exp_lat));
                check("done_count", {26'd0, count}, {26'd0, exp_cnt});
                check("missing_records", 32'(q.size()), 32'd0);
            end
        end
    end

    task automatic build_expected(input bit diff, input int stall_n);
        int n;
        logic [31:0] v;
        n = 0;
        for (int i = 0; i < NREG; i++) begin
            v = (i == 0) ? 32'h0 : rf[i];
            if (!diff || v != sh[i]) begin
                q.push_back('{idx: IDX_W'(i), data: v});
                sh[i] = v;
                n++;
            end
        end
        exp_cnt = 6'(n);
        exp_lat = 2 * n + (NREG - n) + 1 + stall_n;
    endtask

    task automatic run_dump(input bit diff, input int stall_idx, input int stall_n, input bit busy_starts);
        int d0;
        int left;
        logic [31:0] held;
        build_expected(diff, stall_n);
        d0 = done_cnt;
        left = stall_n;
        held = '0;
        diff_only = diff;
        start = 1'b1;
        ob.out_ready = 1'b1;
        step();
        start = 1'b0;
        diff_only = !diff;
        for (int c = 1; c <= 400; c++) begin
            if (done_cnt != d0) break;
            start = busy_starts && (c == 10 || c == 20);
            if (ob.out_valid && int'(ob.out_idx) == stall_idx && left > 0) begin
                if (left == stall_n) begin
                    held = ob.out_data;
                    rf[stall_idx] = rf[stall_idx] ^ 32'hFFFF_0000;
                end else begin
                    check("stall_idx", {27'd0, ob.out_idx}, 32'(stall_idx));
                    check("stall_data", ob.out_data, held);
                end
                ob.out_ready = 1'b0;
                left--;
            end else begin
                ob.out_ready = 1'b1;
            end
            step();
        end
        start = 1'b0;
        ob.out_ready = 1'b1;
        check("dump_finished", 32'(done_cnt != d0), 32'd1);
        repeat (70) step();
        check("single_done", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            rf[i] = '0;
            sh[i] = '0;
        end
        rst = 1'b1;
        start = 1'b0;
        diff_only = 1'b0;
        ob.out_ready = 1'b0;
        repeat (3) step();
        check("rst_out_valid", {31'd0, ob.out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_count", {26'd0, count}, 32'd0);
        check("rst_reg_sel", {27'd0, reg_sel}, 32'd0);
        check("rst_out_idx", {27'd0, ob.out_idx}, 32'd0);
        check("rst_out_data", ob.out_data, 32'd0);
        rst = 1'b0;
        ob.out_ready = 1'b1;
        step();

        rf[1] = 32'h0000_0011;
        rf[2] = 32'h0000_0022;
        run_dump(1'b0, -1, 0, 1'b0);
        check("full_count_idle", {26'd0, count}, 32'd32);

        rf[5] = 32'hDEAD_BEEF;
        run_dump(1'b1, -1, 0, 1'b0);
        check("diff_count_idle", {26'd0, count}, 32'd1);

        run_dump(1'b1, -1, 0, 1'b0);
        check("nochange_count_idle", {26'd0, count}, 32'd0);

        rf[7] = 32'h0000_0077;
        run_dump(1'b0, 7, 3, 1'b0);

        run_dump(1'b1, -1, 0, 1'b1);
        check("busy_start_count", {26'd0, count}, 32'd1);

        begin
            int d0;
            build_expected(1'b0, 0);
            d0 = done_cnt;
            start = 1'b1;
            diff_only = 1'b0;
            step();
            start = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if (ob.out_valid && ob.out_idx == 5'd12) break;
                step();
            end
            check("reached_idx12", {27'd0, ob.out_idx}, 32'd12);
            rst = 1'b1;
            step();
            check("midrst_out_valid", {31'd0, ob.out_valid}, 32'd0);
            check("midrst_busy", {31'd0, busy}, 32'd0);
            check("midrst_done", {31'd0, done}, 32'd0);
            rst = 1'b0;
            q.delete();
            for (int i = 0; i < NREG; i++) sh[i] = '0;
            repeat (5) step();
            check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        end

        rf[30] = 32'h1234_5678;
        run_dump(1'b1, -1, 0, 1'b0);
        check("post_rst_diff_count", {26'd0, count}, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
